// File: rtl/reg_file_onehot_wr.sv
// 32 x WIDTH integer register file with a one-hot write-enable input.
// x0 reads as zero and is never stored. Two combinational read ports,
// with optional write-through bypass, and a debug port that always
// shows stored state. Malformed write-enable vectors are rejected and
// recorded in a sticky flag and a saturating counter.
module reg_file_onehot_wr #(
    parameter int WIDTH     = 32,
    parameter bit BYPASS    = 1'b1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 WE,
    input  logic [31:0]          WEN_VEC,
    input  logic [WIDTH-1:0]     WD,
    input  logic [4:0]           A1,
    input  logic [4:0]           A2,
    input  logic [4:0]           DBG_ADDR,
    output logic [WIDTH-1:0]     RD1,
    output logic [WIDTH-1:0]     RD2,
    output logic [WIDTH-1:0]     DBG_OUT,
    output logic                 ERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic [4:0]           LAST_WR_IDX
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    logic [WIDTH-1:0] regs [32];
    logic             wen_onehot;
    logic             wr_valid;
    logic             wr_viol;
    logic [4:0]       wr_idx;

    // A vector is one-hot when it is nonzero and clearing its lowest set bit leaves nothing.
    assign wen_onehot = (WEN_VEC != 32'd0) && ((WEN_VEC & (WEN_VEC - 32'd1)) == 32'd0);
    assign wr_valid   = WE && wen_onehot;
    assign wr_viol    = WE && !wen_onehot;

    // Encode the write index; only meaningful when the vector is one-hot.
    always_comb begin
        wr_idx = 5'd0;
        for (int k = 0; k < 32; k++) begin
            if (WEN_VEC[k]) begin
                wr_idx = 5'(k);
            end
        end
    end

    // Register storage; x0 is cleared on reset and never written afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 32; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 1; k < 32; k++) begin
                if (wr_valid && WEN_VEC[k]) begin
                    regs[k] <= WD;
                end
            end
        end
    end

    // Write bookkeeping: last committed index, sticky error, saturating violation count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            LAST_WR_IDX <= 5'd0;
            ERR         <= 1'b0;
            ERR_CNT     <= '0;
        end else begin
            if (wr_valid) begin
                LAST_WR_IDX <= wr_idx;
            end
            if (wr_viol) begin
                ERR <= 1'b1;
                if (ERR_CNT != CNT_MAX) begin
                    ERR_CNT <= ERR_CNT + CNT_ONE;
                end
            end
        end
    end

    // Read port 1: zero for x0, write data when bypassing a same-cycle write, else stored value.
    always_comb begin
        RD1 = regs[A1];
        if (A1 == 5'd0) begin
            RD1 = '0;
        end else if (BYPASS && wr_valid && WEN_VEC[A1]) begin
            RD1 = WD;
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        RD2 = regs[A2];
        if (A2 == 5'd0) begin
            RD2 = '0;
        end else if (BYPASS && wr_valid && WEN_VEC[A2]) begin
            RD2 = WD;
        end
    end

    // Debug port never bypasses so it reflects committed state only.
    always_comb begin
        DBG_OUT = regs[DBG_ADDR];
        if (DBG_ADDR == 5'd0) begin
            DBG_OUT = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_onehot_wr.sv
// Directed bench for reg_file_onehot_wr with a queue of expected values.
module tb_reg_file_onehot_wr;

    logic        clk;
    logic        reset_n;
    logic        WE;
    logic [31:0] WEN_VEC;
    logic [31:0] WD;
    logic [4:0]  A1, A2, DBG_ADDR;
    logic [31:0] RD1, RD2, DBG_OUT;
    logic        ERR;
    logic [7:0]  ERR_CNT;
    logic [4:0]  LAST_WR_IDX;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q [$];

    reg_file_onehot_wr #(.WIDTH(32), .BYPASS(1'b1), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .WE(WE), .WEN_VEC(WEN_VEC), .WD(WD),
        .A1(A1), .A2(A2), .DBG_ADDR(DBG_ADDR),
        .RD1(RD1), .RD2(RD2), .DBG_OUT(DBG_OUT),
        .ERR(ERR), .ERR_CNT(ERR_CNT), .LAST_WR_IDX(LAST_WR_IDX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int idx, input logic [31:0] data);
        WE      = 1'b1;
        WEN_VEC = 32'd1 << idx;
        WD      = data;
        step();
        WE      = 1'b0;
        WEN_VEC = 32'd0;
    endtask

    initial begin
        reset_n = 1'b0; WE = 1'b0; WEN_VEC = '0; WD = '0;
        A1 = '0; A2 = '0; DBG_ADDR = '0;
        #13 reset_n = 1'b1;
        #1;

        // Reset state on every address.
        for (int a = 0; a < 32; a++) begin
            A1 = 5'(a); A2 = 5'(a); DBG_ADDR = 5'(a);
            expect_val(0); expect_val(0); expect_val(0);
            #1;
            cmp($sformatf("rst_rd1_%0d", a), RD1);
            cmp($sformatf("rst_rd2_%0d", a), RD2);
            cmp($sformatf("rst_dbg_%0d", a), DBG_OUT);
        end
        expect_val(0); expect_val(0); expect_val(0);
        cmp("rst_err", 32'(ERR));
        cmp("rst_cnt", 32'(ERR_CNT));
        cmp("rst_last", 32'(LAST_WR_IDX));

        // Plain write to x5.
        write_reg(5, 32'hDEADBEEF);
        A1 = 5'd5;
        expect_val(32'hDEADBEEF); expect_val(5);
        #1;
        cmp("wr5_rd1", RD1);
        cmp("wr5_last", 32'(LAST_WR_IDX));

        // Write to x0 is discarded but updates LAST_WR_IDX.
        write_reg(0, 32'h12345678);
        A2 = 5'd0; DBG_ADDR = 5'd0;
        expect_val(0); expect_val(0); expect_val(0);
        #1;
        cmp("wr0_rd2", RD2);
        cmp("wr0_dbg", DBG_OUT);
        cmp("wr0_last", 32'(LAST_WR_IDX));

        // Bypass on x31 before the edge; debug shows old value.
        WE = 1'b1; WEN_VEC = 32'h80000000; WD = 32'hA5A5A5A5;
        A1 = 5'd31; A2 = 5'd31; DBG_ADDR = 5'd31;
        expect_val(32'hA5A5A5A5); expect_val(32'hA5A5A5A5); expect_val(0);
        #1;
        cmp("byp_rd1", RD1);
        cmp("byp_rd2", RD2);
        cmp("byp_dbg_old", DBG_OUT);
        step();
        WE = 1'b0; WEN_VEC = '0; WD = '0;
        expect_val(32'hA5A5A5A5); expect_val(32'hA5A5A5A5); expect_val(31);
        #1;
        cmp("byp_dbg_new", DBG_OUT);
        cmp("byp_rd1_stored", RD1);
        cmp("byp_last", 32'(LAST_WR_IDX));

        // Seed x1/x2, then a two-hot violation must leave them alone.
        write_reg(1, 32'h11111111);
        write_reg(2, 32'h22222222);
        WE = 1'b1; WEN_VEC = 32'h00000006; WD = 32'hFFFFFFFF;
        A1 = 5'd1; A2 = 5'd2;
        expect_val(32'h11111111); expect_val(32'h22222222);
        #1;
        cmp("viol_no_byp_rd1", RD1);
        cmp("viol_no_byp_rd2", RD2);
        step();
        WE = 1'b0; WEN_VEC = '0;
        expect_val(32'h11111111); expect_val(32'h22222222);
        expect_val(1); expect_val(1); expect_val(2);
        #1;
        cmp("viol_x1", RD1);
        cmp("viol_x2", RD2);
        cmp("viol_err", 32'(ERR));
        cmp("viol_cnt1", 32'(ERR_CNT));
        cmp("viol_last_hold", 32'(LAST_WR_IDX));

        // Zero vector with WE=1 is a violation.
        WE = 1'b1; WEN_VEC = 32'd0;
        step();
        WE = 1'b0;
        expect_val(2);
        cmp("viol_zero_cnt2", 32'(ERR_CNT));

        // WE=0 ignores a malformed vector.
        WEN_VEC = 32'h00000006;
        step();
        WEN_VEC = '0;
        expect_val(2); expect_val(1);
        cmp("we0_cnt_hold", 32'(ERR_CNT));
        cmp("we0_err_hold", 32'(ERR));

        // Saturation: 252 more violations reach 254, then 48 more must stop at 255.
        WE = 1'b1; WEN_VEC = 32'h00000003;
        for (int i = 0; i < 252; i++) step();
        expect_val(254);
        cmp("sat_cnt254", 32'(ERR_CNT));
        for (int i = 0; i < 48; i++) step();
        WE = 1'b0; WEN_VEC = '0;
        expect_val(255); expect_val(32'h11111111);
        cmp("sat_cnt255", 32'(ERR_CNT));
        A1 = 5'd1;
        #1;
        cmp("sat_x1_intact", RD1);

        // Asynchronous reset between edges.
        write_reg(10, 32'h55AA55AA);
        DBG_ADDR = 5'd10;
        expect_val(32'h55AA55AA);
        #1;
        cmp("x10_written", DBG_OUT);
        #2 reset_n = 1'b0;
        expect_val(0); expect_val(0); expect_val(0); expect_val(0);
        #1;
        cmp("arst_x10", DBG_OUT);
        cmp("arst_err", 32'(ERR));
        cmp("arst_cnt", 32'(ERR_CNT));
        cmp("arst_last", 32'(LAST_WR_IDX));
        WE = 1'b1; WEN_VEC = 32'h00000400; WD = 32'h55AA55AA;
        step();
        WE = 1'b0; WEN_VEC = '0;
        expect_val(0); expect_val(0);
        cmp("rst_hold_x10", DBG_OUT);
        cmp("rst_hold_last", 32'(LAST_WR_IDX));
        #2 reset_n = 1'b1;

        // Normal operation resumes after reset.
        write_reg(7, 32'hCAFEF00D);
        DBG_ADDR = 5'd7;
        expect_val(32'hCAFEF00D); expect_val(7);
        #1;
        cmp("post_rst_x7", DBG_OUT);
        cmp("post_rst_last", 32'(LAST_WR_IDX));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
